// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and the two-port ALU arbiter:
// opcode values understood by the alu and the arbiter FSM state encoding.
package alu_pkg;

   // Opcodes decoded by the alu; the arbiter passes them through untouched.
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_AND = 4'h7;
   localparam logic [3:0] OP_EQ  = 4'h8;
   localparam logic [3:0] OP_NEQ = 4'h9;
   localparam logic [3:0] OP_SUB = 4'hA;
   localparam logic [3:0] OP_SLT = 4'hC;
   localparam logic [3:0] OP_SGT = 4'hD;
   localparam logic [3:0] OP_ULT = 4'hE;
   localparam logic [3:0] OP_UGE = 4'hF;

   // Arbiter FSM encoding: one operation walks IDLE -> EXEC -> RESP -> IDLE.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath. Compare opcodes return 1/0 in bit 0, unknown
// opcodes return 0. carryout is the adder carry for ADD and the no-borrow
// flag (a >= b) for SUB; it is 0 for every other opcode.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OPW-1:0]   op,
   output logic [WIDTH-1:0] alu_output,
   output logic             carryout,
   output logic             zero_flag
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] res;
   logic             cy;

   // Opcode decode: compute the result word and carry for the selected op.
   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      res  = '0;
      cy   = 1'b0;
      case (op)
         OP_ADD: begin
            res = sum[WIDTH-1:0];
            cy  = sum[WIDTH];
         end
         OP_XOR: res = a ^ b;
         OP_OR:  res = a | b;
         OP_AND: res = a & b;
         OP_EQ:  res = {{(WIDTH-1){1'b0}}, (a == b)};
         OP_NEQ: res = {{(WIDTH-1){1'b0}}, (a != b)};
         OP_SUB: begin
            res = diff[WIDTH-1:0];
            cy  = diff[WIDTH];
         end
         OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SGT: res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
         OP_ULT: res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_UGE: res = {{(WIDTH-1){1'b0}}, (a >= b)};
         default: res = '0;
      endcase
   end

   assign alu_output = res;
   assign carryout   = cy;
   assign zero_flag  = (res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between two requesters.
// Handshake rule (all three channels): a transfer happens on the rising edge
// where valid && ready are both high; ready may depend on valid, a requester
// that sees ready=0 must keep valid and its payload stable.
// One operation is in flight at a time: accept (IDLE), compute (EXEC),
// present the tagged result until consumed (RESP). The served requester
// loses priority once its result is taken.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   output logic             rsp_zero
);

   logic [1:0]       state;
   logic             ptr;
   logic             gnt_id;
   logic             take;
   logic             idle;
   logic             opnd_id;
   logic [WIDTH-1:0] opnd_a;
   logic [WIDTH-1:0] opnd_b;
   logic [OPW-1:0]   opnd_op;
   logic [WIDTH-1:0] alu_out;
   logic             alu_carry;
   logic             alu_zero;

   // Grant selection: a lone requester wins, a tie goes to the pointer.
   always_comb begin
      gnt_id = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_id = ptr;
      end else if (req1_valid) begin
         gnt_id = 1'b1;
      end
   end

   assign idle       = (state == ST_IDLE);
   assign req0_ready = idle && req0_valid && !gnt_id;
   assign req1_ready = idle && req1_valid && gnt_id;
   assign take       = req0_ready || req1_ready;
   assign rsp_valid  = (state == ST_RESP);

   // Operation sequencing: accept, execute for one cycle, hold the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (take) state <= ST_EXEC;
            ST_EXEC: state <= ST_RESP;
            ST_RESP: if (rsp_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Priority pointer: the requester whose result was just consumed yields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (rsp_valid && rsp_ready) begin
         ptr <= ~rsp_id;
      end
   end

   // Operand capture from the granted requester on the accepting edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opnd_id <= 1'b0;
         opnd_a  <= '0;
         opnd_b  <= '0;
         opnd_op <= '0;
      end else if (take) begin
         opnd_id <= gnt_id;
         opnd_a  <= gnt_id ? req1_a  : req0_a;
         opnd_b  <= gnt_id ? req1_b  : req0_b;
         opnd_op <= gnt_id ? req1_op : req0_op;
      end
   end

   alu #(
      .WIDTH(WIDTH),
      .OPW  (OPW)
   ) u_alu (
      .a         (opnd_a),
      .b         (opnd_b),
      .op        (opnd_op),
      .alu_output(alu_out),
      .carryout  (alu_carry),
      .zero_flag (alu_zero)
   );

   // Result registers: loaded once in EXEC, then frozen through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_zero  <= 1'b0;
      end else if (state == ST_EXEC) begin
         rsp_id    <= opnd_id;
         rsp_data  <= alu_out;
         rsp_carry <= alu_carry;
         rsp_zero  <= alu_zero;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: per-port request drivers fed from queues, a
// transaction-level model (arithmetic ALU function, expected-response queue,
// fairness pointer, fixed two-edge latency) checked every cycle, and literal
// checks on the recorded responses of each directed scenario.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero;
   logic [15:0] rsp_data;

   int errors = 0;
   int checks = 0;

   // Driver queues hold {op, a, b}; response entries are {id, carry, zero, data}.
   logic [35:0] drv_q0[$];
   logic [35:0] drv_q1[$];
   logic [18:0] exp_q[$];
   logic [18:0] got_q[$];
   logic        fire0 = 1'b0, fire1 = 1'b0;
   logic        m_pending = 1'b0;
   int          m_age = 0;
   logic        m_ptr = 1'b0;

   alu_arbiter #(.WIDTH(16), .OPW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_valid(req0_valid),
      .req0_ready(req0_ready),
      .req0_a    (req0_a),
      .req0_b    (req0_b),
      .req0_op   (req0_op),
      .req1_valid(req1_valid),
      .req1_ready(req1_ready),
      .req1_a    (req1_a),
      .req1_b    (req1_b),
      .req1_op   (req1_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
      .rsp_zero  (rsp_zero)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ALU behaviour from the opcode table, in plain integer arithmetic.
   function automatic logic [17:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
      int ua = int'(a);
      int ub = int'(b);
      int sa = (ua >= 32768) ? ua - 65536 : ua;
      int sb = (ub >= 32768) ? ub - 65536 : ub;
      int r  = 0;
      bit c  = 1'b0;
      case (op)
         4'h0: begin r = ua + ub; c = (r > 65535); r = r % 65536; end
         4'h4: r = int'(a ^ b);
         4'h6: r = int'(a | b);
         4'h7: r = int'(a & b);
         4'h8: r = (ua == ub) ? 1 : 0;
         4'h9: r = (ua != ub) ? 1 : 0;
         4'hA: begin c = (ua >= ub); r = (ua - ub + 65536) % 65536; end
         4'hC: r = (sa < sb) ? 1 : 0;
         4'hD: r = (sa > sb) ? 1 : 0;
         4'hE: r = (ua < ub) ? 1 : 0;
         4'hF: r = (ua >= ub) ? 1 : 0;
         default: r = 0;
      endcase
      return {c, (r == 0), r[15:0]};
   endfunction

   // Request drivers: present queue head, advance after an observed transfer.
   initial begin
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
      forever begin
         logic f;
         @(posedge clk);
         f = fire0;
         #1;
         if (!rst_n) begin
            drv_q0.delete();
         end else if (f && drv_q0.size() > 0) begin
            void'(drv_q0.pop_front());
         end
         if (drv_q0.size() > 0) begin
            {req0_op, req0_a, req0_b} = drv_q0[0];
            req0_valid = 1'b1;
         end else begin
            req0_valid = 1'b0;
         end
      end
   end

   initial begin
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
      forever begin
         logic f;
         @(posedge clk);
         f = fire1;
         #1;
         if (!rst_n) begin
            drv_q1.delete();
         end else if (f && drv_q1.size() > 0) begin
            void'(drv_q1.pop_front());
         end
         if (drv_q1.size() > 0) begin
            {req1_op, req1_a, req1_b} = drv_q1[0];
            req1_valid = 1'b1;
         end else begin
            req1_valid = 1'b0;
         end
      end
   end

   // Scoreboard: expected grants, latency and response contents every cycle.
   initial begin
      forever begin
         logic exp_r0, exp_r1, exp_v;
         logic [18:0] e;
         @(negedge clk);
         if (!rst_n) begin
            m_pending = 1'b0;
            m_age     = 0;
            m_ptr     = 1'b0;
            exp_q.delete();
            fire0     = 1'b0;
            fire1     = 1'b0;
         end else begin
            if (m_pending) m_age++;
            exp_r0 = !m_pending && req0_valid && (!req1_valid || m_ptr == 1'b0);
            exp_r1 = !m_pending && req1_valid && (!req0_valid || m_ptr == 1'b1);
            check("req0_ready", 32'(req0_ready), 32'(exp_r0));
            check("req1_ready", 32'(req1_ready), 32'(exp_r1));
            exp_v = m_pending && (m_age >= 2);
            check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            if (exp_v && exp_q.size() > 0) begin
               e = exp_q[0];
               check("rsp_id",    32'(rsp_id),    32'(e[18]));
               check("rsp_carry", 32'(rsp_carry), 32'(e[17]));
               check("rsp_zero",  32'(rsp_zero),  32'(e[16]));
               check("rsp_data",  32'(rsp_data),  32'(e[15:0]));
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  got_q.push_back({rsp_id, rsp_carry, rsp_zero, rsp_data});
                  m_ptr     = !e[18];
                  m_pending = 1'b0;
               end
            end
            fire0 = req0_valid && req0_ready;
            fire1 = req1_valid && req1_ready;
            if (fire0) begin
               exp_q.push_back({1'b0, alu_model(req0_op, req0_a, req0_b)});
               m_pending = 1'b1;
               m_age     = 0;
            end
            if (fire1) begin
               exp_q.push_back({1'b1, alu_model(req1_op, req1_a, req1_b)});
               m_pending = 1'b1;
               m_age     = 0;
            end
         end
      end
   end

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         #1;
         if (drv_q0.size() == 0 && drv_q1.size() == 0 && !m_pending) done = 1'b1;
      end
      check({name, "_timeout"}, 32'(done), 32'd1);
   endtask

   task automatic wait_rsp_valid(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check({name, "_rsp_timeout"}, 32'(seen), 32'd1);
   endtask

   task automatic check_got(input string name, input int idx, input logic id,
                            input logic [15:0] data, input logic zero, input logic carry);
      if (idx < got_q.size()) begin
         check({name, "_id"},    32'(got_q[idx][18]),    32'(id));
         check({name, "_carry"}, 32'(got_q[idx][17]),    32'(carry));
         check({name, "_zero"},  32'(got_q[idx][16]),    32'(zero));
         check({name, "_data"},  32'(got_q[idx][15:0]),  32'(data));
      end else begin
         check({name, "_missing"}, 32'(got_q.size()), 32'(idx + 1));
      end
   endtask

   // Directed scenarios
   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data",  32'(rsp_data),  32'd0);
      check("reset_rsp_id",    32'(rsp_id),    32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Simultaneous: pointer 0 after reset, so port 0 first.
      got_q.delete();
      drv_q0.push_back({OP_XOR, 16'h0005, 16'h0005});
      drv_q1.push_back({OP_SUB, 16'h0006, 16'h0005});
      wait_idle("simul");
      check_got("simul0", 0, 1'b0, 16'h0000, 1'b1, 1'b0);
      check_got("simul1", 1, 1'b1, 16'h0001, 1'b0, 1'b1);

      // Fairness: both ports hold valid for four operations.
      got_q.delete();
      drv_q0.push_back({OP_ADD, 16'h0001, 16'h0001});
      drv_q0.push_back({OP_ADD, 16'h8000, 16'h8000});
      drv_q1.push_back({OP_OR,  16'h00F0, 16'h000F});
      drv_q1.push_back({OP_AND, 16'h00F0, 16'h0FFF});
      wait_idle("fair");
      check_got("fair0", 0, 1'b0, 16'h0002, 1'b0, 1'b0);
      check_got("fair1", 1, 1'b1, 16'h00FF, 1'b0, 1'b0);
      check_got("fair2", 2, 1'b0, 16'h0000, 1'b1, 1'b1);
      check_got("fair3", 3, 1'b1, 16'h00F0, 1'b0, 1'b0);

      // Single request on port 0.
      got_q.delete();
      drv_q0.push_back({OP_ADD, 16'h0005, 16'h0004});
      wait_idle("single");
      check_got("single", 0, 1'b0, 16'h0009, 1'b0, 1'b0);

      // Backpressure: result held 5 cycles, port 0 waits meanwhile.
      got_q.delete();
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      drv_q1.push_back({OP_SLT, 16'hFFFA, 16'h0005});
      wait_rsp_valid("bp");
      drv_q0.push_back({OP_EQ, 16'h1234, 16'h1234});
      repeat (5) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_idle("bp");
      check_got("bp0", 0, 1'b1, 16'h0001, 1'b0, 1'b0);
      check_got("bp1", 1, 1'b0, 16'h0001, 1'b0, 1'b0);

      // Undefined opcode.
      got_q.delete();
      drv_q0.push_back({4'h1, 16'h0006, 16'h0004});
      wait_idle("undef");
      check_got("undef", 0, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Reset while the result is presented (pointer is 1 at this point).
      got_q.delete();
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      drv_q0.push_back({OP_ADD, 16'h1234, 16'h0001});
      wait_rsp_valid("rst");
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data",  32'(rsp_data),  32'd0);
      check("rst_rsp_id",    32'(rsp_id),    32'd0);
      check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
      check("rst_rsp_zero",  32'(rsp_zero),  32'd0);
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
      check("rst_state",     32'(dut.state), 32'd0);
      check("rst_ptr",       32'(dut.ptr),   32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_discarded", 32'(got_q.size()), 32'd0);

      // After reset the pointer favours port 0 again.
      drv_q0.push_back({OP_UGE, 16'h0005, 16'h0005});
      drv_q1.push_back({OP_ULT, 16'hFFFF, 16'h0001});
      wait_idle("post_rst");
      check_got("post_rst0", 0, 1'b0, 16'h0001, 1'b0, 1'b0);
      check_got("post_rst1", 1, 1'b1, 16'h0000, 1'b1, 1'b0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
